// File: rtl/fb_pkg.sv
// fb_pkg: shared constants and types for the framebuffer VGA scanout.
// Holds the framebuffer geometry, the 640x480@60 Hz timing defaults with the
// derived totals and sync windows, the RGB444 colour type and the helper that
// maps a (row, col) cell coordinate to its framebuffer bit index.
package fb_pkg;

    // Framebuffer geometry: 40 x 30 cells, each scaled to a 2^CELL_SHIFT pixel square.
    localparam int FB_COLS    = 40;
    localparam int FB_ROWS    = 30;
    localparam int FB_BITS    = 1200;
    localparam int CELL_SHIFT = 4;

    // Horizontal timing in pixels.
    localparam int H_VISIBLE = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

    // Vertical timing in lines.
    localparam int V_VISIBLE = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows (656..751 and 490..491 with the defaults).
    localparam int H_SYNC_START = H_VISIBLE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VISIBLE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    localparam rgb444_t FG_COLOR    = 12'hFFF;
    localparam rgb444_t BG_COLOR    = 12'h000;
    localparam rgb444_t BLANK_COLOR = 12'h000;

    // Row-major cell index, kept 11 bits wide so row*40+col never truncates.
    function automatic logic [10:0] cell_index(input logic [4:0] row, input logic [5:0] col);
        return ({6'd0, row} * 11'd40) + {5'd0, col};
    endfunction

endpackage

// File: rtl/fb_vga_scanout_timing.sv
// vga_timing: pixel-rate timebase for the VGA scanout.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   pix_en              25 MHz enable, toggles every clock, first high on the
//                       second clock after reset release
//   h_count, v_count    current beam position (advance on pix_en only)
//   vga_hs, vga_vs      registered active-low syncs, one pixel tick behind counters
//   active              combinational: counters are inside the visible window
//   snap                combinational one-clock strobe on the last pixel tick of
//                       the last visible line
module vga_timing
    import fb_pkg::*;
#(
    parameter int P_H_VISIBLE = H_VISIBLE,
    parameter int P_H_FP      = H_FP,
    parameter int P_H_SYNC    = H_SYNC,
    parameter int P_H_BP      = H_BP,
    parameter int P_V_VISIBLE = V_VISIBLE,
    parameter int P_V_FP      = V_FP,
    parameter int P_V_SYNC    = V_SYNC,
    parameter int P_V_BP      = V_BP
) (
    input  logic       clock,
    input  logic       reset,
    output logic       pix_en,
    output logic [9:0] h_count,
    output logic [9:0] v_count,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       active,
    output logic       snap
);

    localparam int P_H_TOTAL = P_H_VISIBLE + P_H_FP + P_H_SYNC + P_H_BP;
    localparam int P_V_TOTAL = P_V_VISIBLE + P_V_FP + P_V_SYNC + P_V_BP;

    localparam logic [9:0] H_LAST   = 10'(P_H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(P_V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(P_H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(P_V_VISIBLE);
    localparam logic [9:0] V_VIS_L  = 10'(P_V_VISIBLE - 1);
    localparam logic [9:0] HS_START = 10'(P_H_VISIBLE + P_H_FP);
    localparam logic [9:0] HS_END   = 10'(P_H_VISIBLE + P_H_FP + P_H_SYNC - 1);
    localparam logic [9:0] VS_START = 10'(P_V_VISIBLE + P_V_FP);
    localparam logic [9:0] VS_END   = 10'(P_V_VISIBLE + P_V_FP + P_V_SYNC - 1);

    logic       pix_en_r;
    logic [9:0] h_count_r;
    logic [9:0] v_count_r;
    logic       hs_r;
    logic       vs_r;
    logic       h_end_s;
    logic       v_end_s;
    logic       hs_n_s;
    logic       vs_n_s;

    assign h_end_s = (h_count_r == H_LAST);
    assign v_end_s = (v_count_r == V_LAST);

    // Sync decode from the current counter value; registered below.
    always_comb begin
        hs_n_s = 1'b1;
        vs_n_s = 1'b1;
        if ((h_count_r >= HS_START) && (h_count_r <= HS_END)) begin
            hs_n_s = 1'b0;
        end else begin
            hs_n_s = 1'b1;
        end
        if ((v_count_r >= VS_START) && (v_count_r <= VS_END)) begin
            vs_n_s = 1'b0;
        end else begin
            vs_n_s = 1'b1;
        end
    end

    // Divide-by-two pixel enable.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pix_en_r <= 1'b0;
        end else begin
            pix_en_r <= ~pix_en_r;
        end
    end

    // Beam counters: h wraps at end of line, v steps on each h wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_count_r <= 10'd0;
            v_count_r <= 10'd0;
        end else if (pix_en_r) begin
            if (h_end_s) begin
                h_count_r <= 10'd0;
                if (v_end_s) begin
                    v_count_r <= 10'd0;
                end else begin
                    v_count_r <= v_count_r + 10'd1;
                end
            end else begin
                h_count_r <= h_count_r + 10'd1;
            end
        end
    end

    // Registered syncs, sampled on the same tick as the RGB register in the top.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hs_r <= 1'b1;
            vs_r <= 1'b1;
        end else if (pix_en_r) begin
            hs_r <= hs_n_s;
            vs_r <= vs_n_s;
        end
    end

    assign pix_en  = pix_en_r;
    assign h_count = h_count_r;
    assign v_count = v_count_r;
    assign vga_hs  = hs_r;
    assign vga_vs  = vs_r;
    assign active  = (h_count_r < H_VIS) && (v_count_r < V_VIS);
    assign snap    = pix_en_r && h_end_s && (v_count_r == V_VIS_L);

endmodule

// File: rtl/fb_vga_scanout.sv
// fb_vga_scanout: scans a 40x30 monochrome framebuffer out as 640x480@60 Hz VGA.
// Each cell becomes a square of 2^CELL_SHIFT pixels. The framebuffer is copied
// into a shadow register once per frame, on the last pixel tick of the last
// visible line, so content changes never tear mid-frame; frame_tick marks that copy.
// Ports:
//   clock, reset         50 MHz clock, asynchronous active-high reset
//   framebuffer[1199:0]  cell bitmap, bit[row*40+col], synchronous to clock
//   vga_hs, vga_vs       active-low syncs
//   vga_r/g/b[3:0]       RGB444 pixel, forced to 0 during blanking
//   frame_tick           one-clock pulse per frame, at snapshot time
module fb_vga_scanout
    import fb_pkg::*;
#(
    parameter int      P_CELL_SHIFT = CELL_SHIFT,
    parameter int      P_H_VISIBLE  = H_VISIBLE,
    parameter int      P_H_FP       = H_FP,
    parameter int      P_H_SYNC     = H_SYNC,
    parameter int      P_H_BP       = H_BP,
    parameter int      P_V_VISIBLE  = V_VISIBLE,
    parameter int      P_V_FP       = V_FP,
    parameter int      P_V_SYNC     = V_SYNC,
    parameter int      P_V_BP       = V_BP,
    parameter rgb444_t P_FG_COLOR   = FG_COLOR,
    parameter rgb444_t P_BG_COLOR   = BG_COLOR
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [FB_BITS-1:0]   framebuffer,
    output logic                 vga_hs,
    output logic                 vga_vs,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 frame_tick
);

    logic               pix_en_s;
    logic [9:0]         h_count_s;
    logic [9:0]         v_count_s;
    logic               active_s;
    logic               snap_s;
    logic [5:0]         col_s;
    logic [4:0]         row_s;
    logic [10:0]        cell_idx_s;
    logic               cell_bit_s;
    rgb444_t            rgb_next_s;
    rgb444_t            rgb_r;
    logic [FB_BITS-1:0] shadow_r;
    logic               frame_tick_r;

    vga_timing #(
        .P_H_VISIBLE (P_H_VISIBLE),
        .P_H_FP      (P_H_FP),
        .P_H_SYNC    (P_H_SYNC),
        .P_H_BP      (P_H_BP),
        .P_V_VISIBLE (P_V_VISIBLE),
        .P_V_FP      (P_V_FP),
        .P_V_SYNC    (P_V_SYNC),
        .P_V_BP      (P_V_BP)
    ) u_timing (
        .clock   (clock),
        .reset   (reset),
        .pix_en  (pix_en_s),
        .h_count (h_count_s),
        .v_count (v_count_s),
        .vga_hs  (vga_hs),
        .vga_vs  (vga_vs),
        .active  (active_s),
        .snap    (snap_s)
    );

    // Cell coordinates are the counters with the intra-cell bits dropped; the
    // truncation is exact inside the visible window, which is all that matters.
    assign col_s      = 6'(h_count_s >> P_CELL_SHIFT);
    assign row_s      = 5'(v_count_s >> P_CELL_SHIFT);
    assign cell_idx_s = cell_index(row_s, col_s);

    // Cell lookup and colour mux; out-of-range indices only occur in blanking.
    always_comb begin
        cell_bit_s = 1'b0;
        rgb_next_s = BLANK_COLOR;
        if (cell_idx_s < 11'(FB_BITS)) begin
            cell_bit_s = shadow_r[cell_idx_s];
        end else begin
            cell_bit_s = 1'b0;
        end
        if (active_s) begin
            rgb_next_s = cell_bit_s ? P_FG_COLOR : P_BG_COLOR;
        end else begin
            rgb_next_s = BLANK_COLOR;
        end
    end

    // Shadow copy of the framebuffer, refreshed once per frame.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_r <= {FB_BITS{1'b0}};
        end else if (snap_s) begin
            shadow_r <= framebuffer;
        end
    end

    // Pixel register, aligned with the registered syncs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rgb_r <= BLANK_COLOR;
        end else if (pix_en_s) begin
            rgb_r <= rgb_next_s;
        end
    end

    // Frame tick follows the snapshot strobe for exactly one clock.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_tick_r <= 1'b0;
        end else begin
            frame_tick_r <= snap_s;
        end
    end

    assign vga_r      = rgb_r.r;
    assign vga_g      = rgb_r.g;
    assign vga_b      = rgb_r.b;
    assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_fb_vga_scanout.sv
// Bench for fb_vga_scanout using a reduced raster (cells of 2x2 pixels, 80x60
// visible, 96x67 total) so several frames fit in a short run. The model derives
// every output from a count of clock edges since reset release.
module tb_fb_vga_scanout;

    localparam int HT = 96, VT = 67, HV = 80, VV = 60;
    localparam int HSS = 84, HSE = 89, VSS = 62, VSE = 63;
    localparam int FRAME = HT * VT;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1199:0] framebuffer = '0;
    logic          vga_hs, vga_vs, frame_tick;
    logic [3:0]    vga_r, vga_g, vga_b;
    logic [11:0]   rgb;

    fb_vga_scanout #(
        .P_CELL_SHIFT (1),
        .P_H_VISIBLE  (80), .P_H_FP (4), .P_H_SYNC (6), .P_H_BP (6),
        .P_V_VISIBLE  (60), .P_V_FP (2), .P_V_SYNC (2), .P_V_BP (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .framebuffer (framebuffer),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_tick  (frame_tick)
    );

    always #10 clock = ~clock;
    assign rgb = {vga_r, vga_g, vga_b};

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int            m_e;        // clock edges since reset release
    logic [1199:0] m_shadow;
    logic          m_hs, m_vs, m_tick;
    logic [11:0]   m_rgb;

    function automatic int hc(input int n); return n % HT; endfunction
    function automatic int vc(input int n); return (n / HT) % VT; endfunction
    function automatic logic [11:0] px(input int n, input logic [1199:0] sh);
        int x = hc(n);
        int y = vc(n);
        if (x < HV && y < VV && sh[(y / 2) * 40 + x / 2]) return 12'hFFF;
        return 12'h000;
    endfunction

    // Edge 2k (k>=1) registers pixel number k-1 of the endless raster.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_e <= 0; m_shadow <= '0; m_hs <= 1'b1; m_vs <= 1'b1; m_rgb <= 12'h000; m_tick <= 1'b0;
        end else begin
            m_e <= m_e + 1;
            if (m_e % 2 == 1) begin
                m_hs  <= !(hc((m_e - 1) / 2) >= HSS && hc((m_e - 1) / 2) <= HSE);
                m_vs  <= !(vc((m_e - 1) / 2) >= VSS && vc((m_e - 1) / 2) <= VSE);
                m_rgb <= px((m_e - 1) / 2, m_shadow);
                if (hc((m_e - 1) / 2) == HT - 1 && vc((m_e - 1) / 2) == VV - 1) begin
                    m_shadow <= framebuffer;
                    m_tick   <= 1'b1;
                end else begin
                    m_tick   <= 1'b0;
                end
            end else begin
                m_tick <= 1'b0;
            end
        end
    end

    // ---------------- per-cycle compare and measurements ----------------
    int run = 0;
    logic hs_prev = 1'b1, vs_prev = 1'b1;
    int hs_falls = 0, hs_fall0 = 0, hs_fall1 = 0, hs_low = 0;
    int vs_fall = 0, vs_low = 0;
    int ticks0 = 0, tick0 = 0, tick1 = 0, fg_f1 = 0, fg_late = 0;
    int ticks1 = 0, tick1_first = 0, fg_pre = 0;

    always @(negedge clock) begin
        chk("cycle", 32'({vga_hs, vga_vs, rgb, frame_tick}), 32'({m_hs, m_vs, m_rgb, m_tick}));
        if (!reset) begin
            if (run == 0) begin
                if (hs_prev && !vga_hs) begin
                    if (hs_falls == 0) hs_fall0 = m_e;
                    if (hs_falls == 1) hs_fall1 = m_e;
                    hs_falls++;
                end
                if (!vga_hs && m_e <= 2 * HT) hs_low++;
                if (vs_prev && !vga_vs && vs_fall == 0) vs_fall = m_e;
                if (!vga_vs && m_e <= 2 * FRAME) vs_low++;
                if (frame_tick) begin
                    if (ticks0 == 0) tick0 = m_e;
                    if (ticks0 == 1) tick1 = m_e;
                    ticks0++;
                end
                if (rgb == 12'hFFF && m_e > 11520 && m_e <= 24384) fg_f1++;
                if (rgb == 12'hFFF && m_e > 24384) fg_late++;
            end else begin
                if (frame_tick) begin
                    if (ticks1 == 0) tick1_first = m_e;
                    ticks1++;
                end
                if (rgb == 12'hFFF && m_e <= 11520) fg_pre++;
            end
        end
        hs_prev = vga_hs;
        vs_prev = vga_vs;
    end

    // Advance to the falling clock edge that follows rising edge number e.
    task automatic wait_edge(input int e);
        int guard = 0;
        while (m_e != e && guard < 100000) begin
            @(negedge clock);
            guard++;
        end
        if (m_e != e) begin
            n_vec++;
            n_err++;
            $display("FAIL wait_edge: reached edge %0d, wanted %0d", m_e, e);
        end
    endtask

    // Pixel (x,y) of frame f is on the outputs right after edge 2*(f*FRAME + y*HT + x + 1).
    initial begin
        repeat (5) @(posedge clock);
        #1;
        chk("reset_hs", 32'(vga_hs), 32'd1);
        chk("reset_vs", 32'(vga_vs), 32'd1);
        chk("reset_rgb", 32'(rgb), 32'd0);
        chk("reset_tick", 32'(frame_tick), 32'd0);
        @(negedge clock);
        framebuffer[0]    = 1'b1;
        framebuffer[1199] = 1'b1;
        reset = 1'b0;

        wait_edge(12866); chk("f1_px_0_0", 32'(rgb), 32'hFFF);
        wait_edge(12870); chk("f1_px_2_0", 32'(rgb), 32'h000);
        wait_edge(13060); chk("f1_px_1_1", 32'(rgb), 32'hFFF);
        wait_edge(13250); chk("f1_px_0_2", 32'(rgb), 32'h000);
        wait_edge(20000); framebuffer = '0;
        wait_edge(24348); chk("f1_px_77_59", 32'(rgb), 32'h000);
        wait_edge(24352); chk("f1_px_79_59", 32'(rgb), 32'hFFF);
        wait_edge(24386); framebuffer[0] = 1'b1;
        wait_edge(36000); framebuffer[0] = 1'b0;
        wait_edge(37260); framebuffer = '1;

        // Frame 3, line 30, pixel 85 is inside the hsync pulse.
        wait_edge(44524); chk("pre_reset_hs", 32'(vga_hs), 32'd0);
        #1 reset = 1'b1;
        #1;
        chk("async_hs", 32'(vga_hs), 32'd1);
        chk("async_vs", 32'(vga_vs), 32'd1);
        chk("async_rgb", 32'(rgb), 32'd0);
        repeat (5) @(posedge clock);
        @(negedge clock);
        run = 1;
        reset = 1'b0;

        wait_edge(12866); chk("r1_px_0_0", 32'(rgb), 32'hFFF);
        wait_edge(14956); chk("r1_px_85_10_rgb", 32'(rgb), 32'h000);
        chk("r1_px_85_10_hs", 32'(vga_hs), 32'd0);
        wait_edge(18706); chk("r1_px_40_30", 32'(rgb), 32'hFFF);
        wait_edge(24352); chk("r1_px_79_59", 32'(rgb), 32'hFFF);
        wait_edge(24400);

        chk("hs_fall_first", 32'(hs_fall0), 32'd170);
        chk("hs_fall_second", 32'(hs_fall1), 32'd362);
        chk("hs_low_clocks", 32'(hs_low), 32'd12);
        chk("vs_fall", 32'(vs_fall), 32'd11906);
        chk("vs_low_clocks", 32'(vs_low), 32'd384);
        chk("tick_first", 32'(tick0), 32'd11520);
        chk("tick_second", 32'(tick1), 32'd24384);
        chk("ticks_before_reset", 32'(ticks0), 32'd3);
        chk("fg_frame1", 32'(fg_f1), 32'd16);
        chk("fg_after_bit0_pulse", 32'(fg_late), 32'd0);
        chk("tick_after_reset", 32'(tick1_first), 32'd11520);
        chk("ticks_after_reset", 32'(ticks1), 32'd2);
        chk("fg_before_first_tick", 32'(fg_pre), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
